// File: rtl/config_sequencer.sv
// config_sequencer: loads PE tile configuration from a serial, LSB-first bit
// stream. Each frame carries an 8-bit tile address followed by a 22-bit config
// word. A valid frame produces a one-cycle config_en strobe, and the reserved
// address 8'hFF ends the session.
//
// Optional feature: define CONFIG_SEQ_PARITY_EN to extend frames to 31 bits
// with an even-parity bit (XOR of all 31 bits must be 0). Frames that fail
// parity set err and are not issued, even if they carry the terminator.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        session control (abort has priority)
//   bit_valid, bit_in   serial bit input; transfer when bit_valid && bit_ready
//   bit_ready           high while shifting a frame
//   config_en           one-cycle tile write strobe
//   config_addr/data    registered tile address / config word
//   busy, done          session status
//   frame_count         frames written this session (saturating)
//   err                 sticky session error
module config_sequencer #(
    parameter int unsigned NUM_TILES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        bit_valid,
    input  logic        bit_in,
    output logic        bit_ready,
    output logic        config_en,
    output logic [7:0]  config_addr,
    output logic [21:0] config_data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  frame_count,
    output logic        err
);

`ifdef CONFIG_SEQ_PARITY_EN
    localparam int unsigned FRAME_W = 31;
`else
    localparam int unsigned FRAME_W = 30;
`endif
    localparam int unsigned CNT_W = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);
    localparam logic [7:0]       TERM_ADDR = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-2:0] shreg;
    logic               term_q;

    // Complete frame as seen on the edge that accepts its final bit.
    logic [FRAME_W-1:0] frame_c;
    logic [7:0]         frame_addr_c;
    logic [21:0]        frame_data_c;
    logic               parity_ok_c;
    logic               addr_ok_c;
    logic               is_term_c;

    assign frame_c      = {bit_in, shreg};
    assign frame_addr_c = frame_c[7:0];
    assign frame_data_c = frame_c[29:8];
    assign is_term_c    = (frame_addr_c == TERM_ADDR);
    assign addr_ok_c    = (9'(frame_addr_c) < 9'(NUM_TILES));

`ifdef CONFIG_SEQ_PARITY_EN
    assign parity_ok_c = ~(^frame_c);
`else
    assign parity_ok_c = 1'b1;
`endif

    // Sequencer state, serial shifter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            term_q      <= 1'b0;
            bit_ready   <= 1'b0;
            config_en   <= 1'b0;
            config_addr <= '0;
            config_data <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_count <= '0;
            err         <= 1'b0;
        end else begin
            config_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (abort) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end else if (start) begin
                        state       <= SHIFT;
                        bit_ready   <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        bit_cnt     <= '0;
                        frame_count <= '0;
                        err         <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (abort) begin
                        state     <= IDLE;
                        bit_ready <= 1'b0;
                        busy      <= 1'b0;
                        bit_cnt   <= '0;
                    end else if (bit_valid) begin
                        if (bit_cnt == LAST_BIT) begin
                            // Final bit: decide the frame's fate now so the
                            // strobe lands in the single ISSUE cycle.
                            state     <= ISSUE;
                            bit_ready <= 1'b0;
                            bit_cnt   <= '0;
                            term_q    <= 1'b0;
                            if (!parity_ok_c) begin
                                err <= 1'b1;
                            end else if (is_term_c) begin
                                term_q <= 1'b1;
                            end else if (addr_ok_c) begin
                                config_en   <= 1'b1;
                                config_addr <= frame_addr_c;
                                config_data <= frame_data_c;
                                if (frame_count != 8'hFF) begin
                                    frame_count <= frame_count + 8'd1;
                                end
                            end else begin
                                err <= 1'b1;
                            end
                        end else begin
                            // Shift in from the top so bit 0 ends at shreg[0].
                            shreg   <= {bit_in, shreg[FRAME_W-2:1]};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end

                ISSUE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (term_q) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state     <= SHIFT;
                        bit_ready <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    bit_ready <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
